tc_pl_gain_relay_seq: RTL and testbench

//  Sequencer in front of the CAP0 gain-relay register (OPA0_10X1/10X2/OPX1/OPX2).

---
 rtl/tc_pl_gain_pkg.sv | 22 ++
 rtl/tc_pl_relay_timer.sv | 30 +++
 rtl/tc_pl_gain_relay_seq.sv | 168 ++++++++++++++++
 tb/tb_tc_pl_gain_relay_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tc_pl_gain_pkg.sv
// Shared types and constants for the CAP0 gain-relay sequencer.
package tc_pl_gain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Relay bit positions within the gain pattern
  localparam int unsigned REL_10X1 = 0;
  localparam int unsigned REL_10X2 = 1;
  localparam int unsigned REL_OPX1 = 2;
  localparam int unsigned REL_OPX2 = 3;

  localparam int unsigned DEF_RELAYS     = 4;
  localparam int unsigned DEF_BREAK_CYC  = 1000;
  localparam int unsigned DEF_SETTLE_CYC = 50000;
  localparam int unsigned DEF_CNT_W      = 20;

endpackage

// File: rtl/tc_pl_relay_timer.sv
// Loadable down-counter that stops at zero; expired while it reads zero.
module tc_pl_relay_timer
  import tc_pl_gain_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign value_o   = cnt_q;
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tc_pl_gain_relay_seq.sv
// Break-before-make sequencer driving the CAP0 gain relays, with settle gating
// and a last-wins pending request slot.
module tc_pl_gain_relay_seq
  import tc_pl_gain_pkg::*;
#(
  parameter int unsigned CAP0_14    = DEF_RELAYS,
  parameter int unsigned BREAK_CYC  = DEF_BREAK_CYC,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               gain_req,
  input  logic [CAP0_14-1:0] gain_code,
  output logic               gain_busy,
  output logic               gain_done,
  output logic               settle_ok,
  output logic [CAP0_14-1:0] gain_cur,
  output logic [CAP0_14-1:0] relay_o
);

  localparam int unsigned MAX_CYC = (BREAK_CYC > SETTLE_CYC) ? BREAK_CYC : SETTLE_CYC;

  if (BREAK_CYC == 0 || SETTLE_CYC == 0 || ((MAX_CYC - 1) >> CNT_W) != 0) begin : g_cfg_err
    $error("tc_pl_gain_relay_seq: cycle counts must be >=1 and fit in CNT_W bits");
  end

  state_e             state_q, state_d;
  logic [CAP0_14-1:0] relay_q, relay_d;
  logic [CAP0_14-1:0] cur_q, cur_d;
  logic [CAP0_14-1:0] tgt_q, tgt_d;
  logic [CAP0_14-1:0] pend_code_q, pend_code_d;
  logic               pend_vld_q, pend_vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               settle_q, settle_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_load_val;
  logic [CNT_W-1:0]   tmr_value;
  logic               tmr_expired;
  logic               phase_end;
  logic               req_vld;
  logic [CAP0_14-1:0] req_code;

  tc_pl_relay_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value),
    .expired_o  (tmr_expired)
  );

  assign phase_end = tmr_expired && (tmr_value == '0);

  // Next-state: phase sequencing, pending capture, and start of a new sequence
  always_comb begin
    state_d      = state_q;
    relay_d      = relay_q;
    cur_d        = cur_q;
    tgt_d        = tgt_q;
    pend_code_d  = pend_code_q;
    pend_vld_d   = pend_vld_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    settle_d     = settle_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    req_vld      = 1'b0;
    req_code     = gain_code;

    case (state_q)
      ST_IDLE: begin
        req_vld = gain_req;
      end
      ST_BREAK: begin
        if (gain_req) begin
          pend_code_d = gain_code;
          pend_vld_d  = 1'b1;
        end
        if (phase_end) begin
          state_d      = ST_MAKE;
          relay_d      = tgt_q;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(SETTLE_CYC - 1);
        end
      end
      ST_MAKE: begin
        if (gain_req) begin
          pend_code_d = gain_code;
          pend_vld_d  = 1'b1;
        end
        if (phase_end) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          settle_d = 1'b1;
          cur_d    = tgt_q;
        end
      end
      ST_DONE: begin
        // A strobe in the DONE cycle itself is newer than anything pending
        req_vld    = gain_req | pend_vld_q;
        req_code   = gain_req ? gain_code : pend_code_q;
        pend_vld_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (req_vld) begin
      tgt_d = req_code;
      if (req_code == cur_q) begin
        state_d  = ST_DONE;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        settle_d = 1'b1;
      end else begin
        busy_d   = 1'b1;
        settle_d = 1'b0;
        tmr_load = 1'b1;
        if ((relay_q & ~req_code) != '0) begin
          state_d      = ST_BREAK;
          relay_d      = relay_q & req_code;
          tmr_load_val = CNT_W'(BREAK_CYC - 1);
        end else begin
          state_d      = ST_MAKE;
          relay_d      = req_code;
          tmr_load_val = CNT_W'(SETTLE_CYC - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      relay_q     <= '0;
      cur_q       <= '0;
      tgt_q       <= '0;
      pend_code_q <= '0;
      pend_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      settle_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      relay_q     <= relay_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      pend_code_q <= pend_code_d;
      pend_vld_q  <= pend_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      settle_q    <= settle_d;
    end
  end

  assign relay_o   = relay_q;
  assign gain_cur  = cur_q;
  assign gain_busy = busy_q;
  assign gain_done = done_q;
  assign settle_ok = settle_q;

endmodule

// File: tb/tb_tc_pl_gain_relay_seq.sv
// Directed bench for the gain-relay sequencer with BREAK_CYC=4, SETTLE_CYC=8.
module tb_tc_pl_gain_relay_seq;

  logic       clk;
  logic       rst_n;
  logic       gain_req;
  logic [3:0] gain_code;
  logic       gain_busy;
  logic       gain_done;
  logic       settle_ok;
  logic [3:0] gain_cur;
  logic [3:0] relay_o;

  int checks;
  int failures;
  int done_cnt;

  tc_pl_gain_relay_seq #(
    .CAP0_14    (4),
    .BREAK_CYC  (4),
    .SETTLE_CYC (8),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gain_req  (gain_req),
    .gain_code (gain_code),
    .gain_busy (gain_busy),
    .gain_done (gain_done),
    .settle_ok (settle_ok),
    .gain_cur  (gain_cur),
    .relay_o   (relay_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drop the request strobe, then check the visible outputs
  task automatic cyc(input string tag, input logic [3:0] r, input logic b,
                     input logic s, input logic d);
    @(posedge clk);
    #1;
    gain_req = 1'b0;
    chk4({tag, "_relay"}, relay_o, r);
    chk1({tag, "_busy"}, gain_busy, b);
    chk1({tag, "_settle"}, settle_ok, s);
    chk1({tag, "_done"}, gain_done, d);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    gain_req  = 1'b0;
    gain_code = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk4("rst_relay", relay_o, 4'b0000);
    chk4("rst_cur", gain_cur, 4'b0000);
    chk1("rst_busy", gain_busy, 1'b0);
    chk1("rst_done", gain_done, 1'b0);
    chk1("rst_settle", settle_ok, 1'b1);

    // gain_code without a strobe is ignored
    gain_code = 4'b1111;
    cyc("noreq0", 4'b0000, 1'b0, 1'b1, 1'b0);
    cyc("noreq1", 4'b0000, 1'b0, 1'b1, 1'b0);

    // 0000 -> 0101: no break, done at t+9
    gain_req = 1'b1; gain_code = 4'b0101;
    for (int i = 1; i <= 8; i++) cyc("s2_make", 4'b0101, 1'b1, 1'b0, 1'b0);
    cyc("s2_done", 4'b0101, 1'b0, 1'b1, 1'b1);
    chk4("s2_cur", gain_cur, 4'b0101);
    cyc("s2_idle", 4'b0101, 1'b0, 1'b1, 1'b0);

    // 0101 -> 0110: bit0 released first, done at t+13
    gain_req = 1'b1; gain_code = 4'b0110;
    for (int i = 1; i <= 4; i++) cyc("s3_break", 4'b0100, 1'b1, 1'b0, 1'b0);
    for (int i = 5; i <= 12; i++) cyc("s3_make", 4'b0110, 1'b1, 1'b0, 1'b0);
    cyc("s3_done", 4'b0110, 1'b0, 1'b1, 1'b1);
    chk4("s3_cur", gain_cur, 4'b0110);

    // Same code as current: done next cycle, settle never drops
    gain_req = 1'b1; gain_code = 4'b0110;
    cyc("s4_done", 4'b0110, 1'b0, 1'b1, 1'b1);
    cyc("s4_idle", 4'b0110, 1'b0, 1'b1, 1'b0);
    chk4("s4_cur", gain_cur, 4'b0110);

    // Reset mid-BREAK of 0110 -> 0011
    gain_req = 1'b1; gain_code = 4'b0011;
    cyc("s1_break0", 4'b0010, 1'b1, 1'b0, 1'b0);
    cyc("s1_break1", 4'b0010, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("s1_rst_relay", relay_o, 4'b0000);
    chk1("s1_rst_busy", gain_busy, 1'b0);
    chk1("s1_rst_settle", settle_ok, 1'b1);
    chk4("s1_rst_cur", gain_cur, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (gain_done) done_cnt++;
    end
    chk4("s1_no_done", 4'(done_cnt), 4'd0);
    chk4("s1_post_relay", relay_o, 4'b0000);
    chk1("s1_post_busy", gain_busy, 1'b0);

    // 0000 -> 0001 with 0010 then 1000 arriving mid-sequence; last wins
    gain_req = 1'b1; gain_code = 4'b0001;
    cyc("s5_make_a1", 4'b0001, 1'b1, 1'b0, 1'b0);
    gain_req = 1'b1; gain_code = 4'b0010;
    cyc("s5_make_a2", 4'b0001, 1'b1, 1'b0, 1'b0);
    gain_req = 1'b1; gain_code = 4'b1000;
    for (int i = 3; i <= 8; i++) cyc("s5_make_a", 4'b0001, 1'b1, 1'b0, 1'b0);
    cyc("s5_done_a", 4'b0001, 1'b0, 1'b1, 1'b1);
    chk4("s5_cur_a", gain_cur, 4'b0001);
    for (int i = 10; i <= 13; i++) cyc("s5_break_b", 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 14; i <= 21; i++) cyc("s5_make_b", 4'b1000, 1'b1, 1'b0, 1'b0);
    cyc("s5_done_b", 4'b1000, 1'b0, 1'b1, 1'b1);
    chk4("s5_cur_b", gain_cur, 4'b1000);
    cyc("s5_idle", 4'b1000, 1'b0, 1'b1, 1'b0);

    // 1000 -> 1100, then a request exactly in the DONE cycle for 0100
    gain_req = 1'b1; gain_code = 4'b1100;
    for (int i = 1; i <= 8; i++) cyc("s6_make_a", 4'b1100, 1'b1, 1'b0, 1'b0);
    cyc("s6_done_a", 4'b1100, 1'b0, 1'b1, 1'b1);
    chk4("s6_cur_a", gain_cur, 4'b1100);
    gain_req = 1'b1; gain_code = 4'b0100;
    for (int i = 10; i <= 13; i++) cyc("s6_break_b", 4'b0100, 1'b1, 1'b0, 1'b0);
    for (int i = 14; i <= 21; i++) cyc("s6_make_b", 4'b0100, 1'b1, 1'b0, 1'b0);
    cyc("s6_done_b", 4'b0100, 1'b0, 1'b1, 1'b1);
    chk4("s6_cur_b", gain_cur, 4'b0100);
    cyc("s6_idle", 4'b0100, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
